// File: rtl/sdp_bram_lpm_pkg.sv
// Shared widths and FSM encoding for the LPM BRAM controller slice.
package sdp_bram_lpm_pkg;

  localparam int unsigned LPM_ADDR_W = 10;
  localparam int unsigned LPM_DATA_W = 75;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } lpm_state_t;

endpackage

// File: rtl/lpm_wr_rr_arb.sv
// Two-way round-robin write arbiter.
// Ports: clk/rst, en (arbitration allowed), valid[1:0] requests, grant[1:0] one-hot
// combinational grant. The pointer only moves when both requesters contend.
module lpm_wr_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic rr_ptr_q;

  // Grant decode; rr_ptr selects the winner on contention
  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Pointer flips to the loser after a contended grant
  always_ff @(posedge clk) begin
    if (rst)                rr_ptr_q <= 1'b0;
    else if (en && &valid)  rr_ptr_q <= ~rr_ptr_q;
  end

endmodule

// File: rtl/sdp_bram_lpm.sv
// Simple-dual-port RAM: port A writes, port B reads through a registered address.
// Ports: clka/wea/addra/dina write side; clkb/rstb/addrb read side, doutb read data.
// Registering the read address makes a same-cycle write to that address visible
// on doutb in the following cycle (write-first).
module sdp_bram_lpm
  import sdp_bram_lpm_pkg::*;
#(
  parameter int unsigned ADDR_W = LPM_ADDR_W,
  parameter int unsigned DATA_W = LPM_DATA_W
) (
  input  logic              clka,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              clkb,
  input  logic              rstb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addrb_q;

  // Write port
  always_ff @(posedge clka) begin
    if (wea) mem[addra] <= dina;
  end

  // Read address register
  always_ff @(posedge clkb) begin
    if (rstb) addrb_q <= '0;
    else      addrb_q <= addrb;
  end

  assign doutb = mem[addrb_q];

endmodule

// File: rtl/sdp_bram_lpm_ctrl.sv
// Controller sharing the LPM SDP BRAM between two writers and one reader.
// Zero-fills the memory after reset, arbitrates writes round-robin and returns
// read data one cycle after acceptance with rd_valid.
// Ports: clk/rst; w0_*/w1_* write requesters (valid/addr/data/ready);
// r_valid/r_addr/r_ready read request; rd_valid/rd_data read response;
// init_done; bram_* connect straight to sdp_bram_lpm (clka/clkb tied to clk).
module sdp_bram_lpm_ctrl
  import sdp_bram_lpm_pkg::*;
#(
  parameter int unsigned ADDR_W        = LPM_ADDR_W,
  parameter int unsigned DATA_W        = LPM_DATA_W,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w0_valid,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  output logic              w0_ready,
  input  logic              w1_valid,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  output logic              w1_ready,
  input  logic              r_valid,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              bram_wea,
  output logic              bram_rstb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_doutb
);

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  lpm_state_t        state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q;
  logic [ADDR_W-1:0] addra_q;
  logic [DATA_W-1:0] dina_q;
  logic              rd_valid_q;
  logic              init_done_q;
  logic              run;
  logic [1:0]        grant;

  // Held in reset so nothing is accepted during the rst cycle
  assign run = (state_q == ST_RUN) && !rst;

  lpm_wr_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (run),
    .valid ({w1_valid, w0_valid}),
    .grant (grant)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT_ON_RESET ? ST_INIT : ST_RUN;
    else     state_q <= state_d;
  end

  // Next state and write-port drive; the write port holds its last address/data when idle
  always_comb begin
    state_d    = state_q;
    bram_wea   = 1'b0;
    bram_addra = addra_q;
    bram_dina  = dina_q;
    if (!rst) begin
      unique case (state_q)
        ST_INIT: begin
          bram_wea   = 1'b1;
          bram_addra = init_cnt_q;
          bram_dina  = '0;
          if (init_cnt_q == CNT_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (grant[0]) begin
            bram_wea   = 1'b1;
            bram_addra = w0_addr;
            bram_dina  = w0_data;
          end else if (grant[1]) begin
            bram_wea   = 1'b1;
            bram_addra = w1_addr;
            bram_dina  = w1_data;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // Write-port hold registers
  always_ff @(posedge clk) begin
    addra_q <= bram_addra;
    dina_q  <= bram_dina;
  end

  // Zero-fill counter, read pipeline and init flag
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt_q  <= '0;
      rd_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + ADDR_W'(1);
      rd_valid_q  <= r_valid & run;
      init_done_q <= (state_d == ST_RUN);
    end
  end

  assign w0_ready   = grant[0];
  assign w1_ready   = grant[1];
  assign r_ready    = run;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = bram_doutb;
  assign init_done  = init_done_q;
  assign bram_rstb  = rst;
  assign bram_addrb = r_addr;

endmodule

// File: tb/tb_sdp_bram_lpm_ctrl.sv
// Scoreboard bench for sdp_bram_lpm_ctrl driving a real sdp_bram_lpm.
module tb_sdp_bram_lpm_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 75;

  logic          clk = 1'b0;
  logic          rst;
  logic          w0_valid, w1_valid, r_valid;
  logic [AW-1:0] w0_addr, w1_addr, r_addr;
  logic [DW-1:0] w0_data, w1_data;
  logic          w0_ready, w1_ready, r_ready;
  logic          rd_valid, init_done;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] bram_addra, bram_addrb;
  logic [DW-1:0] bram_dina, bram_doutb;
  logic          bram_wea, bram_rstb;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   due;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  sdp_bram_lpm_ctrl dut (
    .clk(clk), .rst(rst),
    .w0_valid(w0_valid), .w0_addr(w0_addr), .w0_data(w0_data), .w0_ready(w0_ready),
    .w1_valid(w1_valid), .w1_addr(w1_addr), .w1_data(w1_data), .w1_ready(w1_ready),
    .r_valid(r_valid), .r_addr(r_addr), .r_ready(r_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .init_done(init_done),
    .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
    .bram_rstb(bram_rstb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
  );

  sdp_bram_lpm u_bram (
    .clka(clk), .wea(bram_wea), .addra(bram_addra), .dina(bram_dina),
    .clkb(clk), .rstb(bram_rstb), .addrb(bram_addrb), .doutb(bram_doutb)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w0_valid = 1'b0;
    w1_valid = 1'b0;
    r_valid  = 1'b0;
  endtask

  // Issue a read this cycle; its result is due in the next cycle
  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    r_valid = 1'b1;
    r_addr  = a;
    e.data  = d;
    e.due   = cyc_cnt + 1;
    exp_q.push_back(e);
  endtask

  // Pops the scoreboard whenever the DUT presents read data
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected", DW'(1), DW'(0));
        end else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data, e.data);
          check("rd_latency", DW'(cyc_cnt), DW'(e.due));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc_cnt) begin
        e = exp_q.pop_front();
        check("rd_missing", DW'(0), DW'(1));
      end
    end
  endtask

  task automatic wait_init();
    int n = 0;
    while (init_done !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    check("init_latency", DW'(n), DW'(1024));
  endtask

  initial begin
    int acc0 = 0;
    int acc1 = 0;
    int k = 0;
    rst = 1'b1;
    idle();
    w0_addr = '0; w1_addr = '0; r_addr = '0;
    w0_data = '0; w1_data = '0;
    fork
      monitor();
    join_none

    // Reset cycle: everything quiet even with requests pending
    repeat (2) @(posedge clk);
    #1;
    w0_valid = 1'b1; r_valid = 1'b1;
    @(negedge clk);
    check("rst_wea", DW'(bram_wea), DW'(0));
    check("rst_w0_ready", DW'(w0_ready), DW'(0));
    check("rst_r_ready", DW'(r_ready), DW'(0));
    check("rst_rd_valid", DW'(rd_valid), DW'(0));
    check("rst_init_done", DW'(init_done), DW'(0));
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("init_wea", DW'(bram_wea), DW'(1));
    check("init_addra", DW'(bram_addra), DW'(0));
    check("init_dina", bram_dina, DW'(0));
    check("init_r_ready", DW'(r_ready), DW'(0));
    // After the rst edge, zero-fill takes 1024 edges
    begin
      int n = 0;
      while (init_done !== 1'b1 && n < 2000) begin
        @(posedge clk); #1; n++;
      end
      check("init_latency", DW'(n), DW'(1024));
    end

    // Zero-filled reads
    rd(10'd0, '0);    step();
    rd(10'd511, '0);  step();
    rd(10'd1023, '0); step();
    idle(); step();

    // Single writer
    w0_valid = 1'b1; w0_addr = 10'd5; w0_data = 75'h1;
    @(negedge clk);
    check("w0_ready_single", DW'(w0_ready), DW'(1));
    check("w1_ready_single", DW'(w1_ready), DW'(0));
    check("addra_single", DW'(bram_addra), DW'(5));
    step();
    idle();
    rd(10'd5, 75'h1);
    @(negedge clk);
    check("idle_wea", DW'(bram_wea), DW'(0));
    check("idle_addra_hold", DW'(bram_addra), DW'(5));
    step();
    idle();

    // Contention: grants alternate 0,1,0,1
    w0_valid = 1'b1; w0_addr = 10'd10; w0_data = 75'h0A0A;
    w1_valid = 1'b1; w1_addr = 10'd11; w1_data = 75'h0B0B;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_w0_ready", DW'(w0_ready), DW'(i % 2 == 0));
      check("rr_w1_ready", DW'(w1_ready), DW'(i % 2 == 1));
      check("rr_addra", DW'(bram_addra), (i % 2 == 0) ? DW'(10) : DW'(11));
      acc0 += int'(w0_ready);
      acc1 += int'(w1_ready);
      step();
    end
    check("rr_acc0", DW'(acc0), DW'(2));
    check("rr_acc1", DW'(acc1), DW'(2));
    idle();
    rd(10'd10, 75'h0A0A); step();
    rd(10'd11, 75'h0B0B); step();
    idle();

    // Same-cycle write and read of one address returns the new data
    w1_valid = 1'b1; w1_addr = 10'd7; w1_data = 75'h2A;
    rd(10'd7, 75'h2A);
    step();
    idle(); step();

    // Fill 0..15 then burst-read them back
    for (int i = 0; i < 16; i++) begin
      w0_valid = 1'b1; w0_addr = AW'(i); w0_data = DW'(32'h1000 + i);
      step();
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      rd(AW'(i), DW'(32'h1000 + i));
      step();
    end
    idle(); step();

    // Reset mid-burst
    rd(10'd0, 75'h1000); step();
    rd(10'd1, 75'h1001); step();
    rst = 1'b1;
    r_valid = 1'b1; r_addr = 10'd2;
    w0_valid = 1'b1; w0_addr = 10'd9; w0_data = 75'h5;
    @(negedge clk);
    check("mid_rst_wea", DW'(bram_wea), DW'(0));
    check("mid_rst_r_ready", DW'(r_ready), DW'(0));
    check("mid_rst_w0_ready", DW'(w0_ready), DW'(0));
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("post_rst_rd_valid", DW'(rd_valid), DW'(0));
    check("post_rst_init_done", DW'(init_done), DW'(0));
    check("post_rst_wea", DW'(bram_wea), DW'(1));
    check("post_rst_addra", DW'(bram_addra), DW'(0));
    wait_init();
    rd(10'd3, '0); step();
    rd(10'd5, '0); step();
    rd(10'd7, '0); step();
    idle();

    while (exp_q.size() != 0 && k < 20) begin
      step();
      k++;
    end
    check("drain", DW'(exp_q.size()), DW'(0));
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
